// File: rtl/riscv_pkg.sv
// Shared encodings for the write-back stage: result selects, load funct3 codes, FSM states.
// The optional load watchdog is enabled with the WB_LOAD_TIMEOUT_EN macro (see wb_stage).
package riscv_pkg;

  localparam logic [1:0] WbSelAlu  = 2'd0;
  localparam logic [1:0] WbSelLoad = 2'd1;
  localparam logic [1:0] WbSelPc4  = 2'd2;
  localparam logic [1:0] WbSelRsvd = 2'd3;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StCommit,
    StWaitLoad
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment: picks the byte/halfword addressed by the low address
// bits and sign- or zero-extends it to XLEN.
module load_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lsb_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  always_comb begin
    shifted = rdata_i >> {addr_lsb_i, 3'b000};
    ld_byte = shifted[7:0];
    // Halfwords are naturally aligned; bit 0 of the offset is ignored.
    ld_half = addr_lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    unique case (funct3_i)
      F3Lb:    data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3Lbu:   data_o = {{(XLEN-8){1'b0}}, ld_byte};
      F3Lh:    data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3Lhu:   data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: captures an executed instruction, waits for load data when needed and
// drives the register-file write port. Define WB_LOAD_TIMEOUT_EN to add the load watchdog/err_o.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REGW         = 5,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic            ex_reg_we_i,
  input  logic [REGW-1:0] ex_rd_i,
  input  logic [1:0]      ex_wb_sel_i,
  input  logic [XLEN-1:0] ex_alu_i,
  input  logic [XLEN-1:0] ex_pc4_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [1:0]      ex_addr_lsb_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            rf_we_o,
  output logic [REGW-1:0] rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o
`ifdef WB_LOAD_TIMEOUT_EN
  ,
  output logic            err_o
`endif
);

  wb_state_e       state_q, state_d;
  logic            capture;
  logic            tmo_hit;
  logic            reg_we_q;
  logic [REGW-1:0] rd_q;
  logic [2:0]      funct3_q;
  logic [1:0]      lsb_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] load_data;

  assign capture = ex_valid_i & ~stall_o;

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3_i  (funct3_q),
    .addr_lsb_i(lsb_q),
    .rdata_i   (dmem_rdata_i),
    .data_o    (load_data)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (capture) begin
          state_d = (ex_wb_sel_i == WbSelLoad) ? StWaitLoad : StCommit;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitLoad: begin
        if (dmem_rvalid_i) begin
          state_d = StCommit;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: address/data come straight from registers so they are settled all COMMIT cycle.
  always_comb begin
    stall_o    = (state_q == StWaitLoad);
    rf_we_o    = (state_q == StCommit) && reg_we_q && (rd_q != '0);
    rf_waddr_o = rd_q;
    rf_wdata_o = result_q;
  end

  // Stage register. Non-load results are resolved at capture; load results on the response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_we_q <= 1'b0;
      rd_q     <= '0;
      funct3_q <= '0;
      lsb_q    <= '0;
      result_q <= '0;
    end else if (capture) begin
      reg_we_q <= ex_reg_we_i;
      rd_q     <= ex_rd_i;
      funct3_q <= ex_funct3_i;
      lsb_q    <= ex_addr_lsb_i;
      unique case (ex_wb_sel_i)
        WbSelPc4:  result_q <= ex_pc4_i;
        WbSelLoad: result_q <= result_q;
        default:   result_q <= ex_alu_i;
      endcase
    end else if (state_q == StWaitLoad && dmem_rvalid_i) begin
      result_q <= load_data;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LOAD_TIMEOUT + 1);

  logic [CntW-1:0] tmo_cnt_q;
  logic            err_q;

  // tmo_cnt_q holds the number of WAIT_LOAD cycles already spent; a response wins a tie.
  assign tmo_hit = (state_q == StWaitLoad) && !dmem_rvalid_i
                   && (tmo_cnt_q == CntW'(LOAD_TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= tmo_hit;
      if (state_q == StWaitLoad && state_d == StWaitLoad) begin
        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU/PC+4/load paths, back-to-back commits,
// rd=0 suppression, asynchronous reset mid-load and (with WB_LOAD_TIMEOUT_EN) the watchdog.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_reg_we = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [1:0]  ex_wb_sel = '0;
  logic [31:0] ex_alu = '0;
  logic [31:0] ex_pc4 = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_addr_lsb = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_LOAD_TIMEOUT_EN
  logic        err;
`endif

  int total = 0;
  int bad   = 0;

  wb_stage #(
    .XLEN        (32),
    .REGW        (5),
    .LOAD_TIMEOUT(16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .ex_valid_i   (ex_valid),
    .ex_reg_we_i  (ex_reg_we),
    .ex_rd_i      (ex_rd),
    .ex_wb_sel_i  (ex_wb_sel),
    .ex_alu_i     (ex_alu),
    .ex_pc4_i     (ex_pc4),
    .ex_funct3_i  (ex_funct3),
    .ex_addr_lsb_i(ex_addr_lsb),
    .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i (dmem_rdata),
    .stall_o      (stall),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata)
`ifdef WB_LOAD_TIMEOUT_EN
    ,
    .err_o        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [2:0] f3, input logic [1:0] lsb);
    ex_valid    = 1'b1;
    ex_reg_we   = we;
    ex_rd       = rd;
    ex_wb_sel   = sel;
    ex_alu      = alu;
    ex_pc4      = pc4;
    ex_funct3   = f3;
    ex_addr_lsb = lsb;
  endtask

  // Capture a load, respond on the next WAIT_LOAD cycle, check the committed data.
  task automatic load1(input string tag, input logic [2:0] f3, input logic [1:0] lsb,
                       input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 5'd9, 2'd1, 32'h0, 32'h0, f3, lsb);
    tick();
    ex_valid = 1'b0;
    chk({tag, "_stall"}, {31'b0, stall}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
    chk({tag, "_we"}, {31'b0, rf_we}, 32'd1);
    chk({tag, "_data"}, rf_wdata, exp);
    tick();
  endtask

  initial begin
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_we", {31'b0, rf_we}, 32'd0);
    chk("rst_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Single ALU op: written exactly one cycle after capture.
    issue(1'b1, 5'd5, 2'd0, 32'hDEADBEEF, 32'h0000_1004, 3'd0, 2'd0);
    tick();
    ex_valid = 1'b0;
    chk("alu_we", {31'b0, rf_we}, 32'd1);
    chk("alu_waddr", {27'b0, rf_waddr}, 32'd5);
    chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
    chk("alu_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("alu_idle_we", {31'b0, rf_we}, 32'd0);

    // PC+4 select and reserved select (treated as ALU).
    issue(1'b1, 5'd1, 2'd2, 32'h1111_1111, 32'h0000_2008, 3'd0, 2'd0);
    tick();
    ex_valid = 1'b0;
    chk("pc4_wdata", rf_wdata, 32'h0000_2008);
    tick();
    issue(1'b1, 5'd2, 2'd3, 32'h3333_3333, 32'h4444_4444, 3'd0, 2'd0);
    tick();
    ex_valid = 1'b0;
    chk("rsvd_wdata", rf_wdata, 32'h3333_3333);
    tick();

    // LB at offset 3, response two WAIT_LOAD cycles in.
    issue(1'b1, 5'd7, 2'd1, 32'h0, 32'h0, 3'b000, 2'd3);
    tick();
    ex_valid = 1'b0;
    chk("lb_stall1", {31'b0, stall}, 32'd1);
    chk("lb_we1", {31'b0, rf_we}, 32'd0);
    tick();
    chk("lb_stall2", {31'b0, stall}, 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_stall3", {31'b0, stall}, 32'd0);
    chk("lb_we", {31'b0, rf_we}, 32'd1);
    chk("lb_waddr", {27'b0, rf_waddr}, 32'd7);
    chk("lb_wdata", rf_wdata, 32'hFFFF_FF80);
    tick();

    load1("lhu", 3'b101, 2'd2, 32'h8001_1234, 32'h0000_8001);
    load1("lh", 3'b001, 2'd2, 32'h8001_1234, 32'hFFFF_8001);
    load1("lh_lo", 3'b001, 2'd1, 32'h8001_1234, 32'h0000_1234);
    load1("lbu", 3'b100, 2'd1, 32'h1234_80AB, 32'h0000_0080);
    load1("lw", 3'b010, 2'd3, 32'hCAFE_F00D, 32'hCAFE_F00D);
    load1("f3_011", 3'b011, 2'd1, 32'h0BAD_CAFE, 32'h0BAD_CAFE);

    // rd = 0 never writes.
    issue(1'b1, 5'd0, 2'd0, 32'h5555_5555, 32'h0, 3'd0, 2'd0);
    tick();
    ex_valid = 1'b0;
    chk("rd0_we", {31'b0, rf_we}, 32'd0);
    tick();

    // Three back-to-back ALU ops: three consecutive write cycles.
    issue(1'b1, 5'd10, 2'd0, 32'h0000_000A, 32'h0, 3'd0, 2'd0);
    tick();
    issue(1'b1, 5'd11, 2'd0, 32'h0000_000B, 32'h0, 3'd0, 2'd0);
    chk("b2b1_we", {31'b0, rf_we}, 32'd1);
    chk("b2b1_data", rf_wdata, 32'h0000_000A);
    tick();
    issue(1'b1, 5'd12, 2'd0, 32'h0000_000C, 32'h0, 3'd0, 2'd0);
    chk("b2b2_we", {31'b0, rf_we}, 32'd1);
    chk("b2b2_addr", {27'b0, rf_waddr}, 32'd11);
    chk("b2b2_data", rf_wdata, 32'h0000_000B);
    tick();
    ex_valid = 1'b0;
    chk("b2b3_we", {31'b0, rf_we}, 32'd1);
    chk("b2b3_data", rf_wdata, 32'h0000_000C);
    tick();
    chk("b2b_end_we", {31'b0, rf_we}, 32'd0);

    // Asynchronous reset during WAIT_LOAD; late response must be ignored.
    issue(1'b1, 5'd13, 2'd1, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    ex_valid = 1'b0;
    chk("rstw_stall_pre", {31'b0, stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rstw_stall", {31'b0, stall}, 32'd0);
    chk("rstw_we", {31'b0, rf_we}, 32'd0);
    chk("rstw_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rstw_wdata", rf_wdata, 32'd0);
    #1;
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h7777_7777;
    tick();
    dmem_rvalid = 1'b0;
    chk("late_we", {31'b0, rf_we}, 32'd0);
    chk("late_stall", {31'b0, stall}, 32'd0);
    chk("late_wdata", rf_wdata, 32'd0);

`ifdef WB_LOAD_TIMEOUT_EN
    // No response: 16 WAIT_LOAD cycles, then err pulse and return to IDLE.
    issue(1'b1, 5'd14, 2'd1, 32'h0, 32'h0, 3'b010, 2'd0);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("tmo_stall", {31'b0, stall}, 32'd1);
      chk("tmo_err_low", {31'b0, err}, 32'd0);
      if (i < 15) tick();
    end
    tick();
    chk("tmo_err", {31'b0, err}, 32'd1);
    chk("tmo_stall_drop", {31'b0, stall}, 32'd0);
    chk("tmo_we", {31'b0, rf_we}, 32'd0);
    tick();
    chk("tmo_err_pulse", {31'b0, err}, 32'd0);
    chk("tmo_we2", {31'b0, rf_we}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
